// File: rtl/mdu_iter_if.sv
// Operand/result bundle between the issuing pipeline and the iterative multiply/divide unit.
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             start;
  logic             busy;
  logic             done;

  modport master (
    output op, rs_val, rt_val, cancel,
    input  hi, lo, start, busy, done
  );

  modport slave (
    input  op, rs_val, rt_val, cancel,
    output hi, lo, start, busy, done
  );
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle HI/LO multiply/divide unit: fixed-latency multiply, restoring divide
// (one quotient bit per cycle) followed by a single sign-fixup cycle.
module mdu_iter #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input logic        clk,
  input logic        reset,
  mdu_iter_if.slave  bus
);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam int CW = ($clog2(WIDTH) > 6) ? $clog2(WIDTH) : 6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             sgn_reg, sgn_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic             zero_reg, zero_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  logic [WIDTH:0]     diff;
  logic               rs_neg, rt_neg;

  // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are then exact.
  assign mul_a   = {{WIDTH{sgn_reg & a_reg[WIDTH-1]}}, a_reg};
  assign mul_b   = {{WIDTH{sgn_reg & b_reg[WIDTH-1]}}, b_reg};
  assign product = mul_a * mul_b;

  // a_reg doubles as the dividend shift register that fills with quotient bits.
  assign diff   = {rem_reg, a_reg[WIDTH-1]} - {1'b0, b_reg};
  assign rs_neg = (bus.op == OP_DIV) & bus.rs_val[WIDTH-1];
  assign rt_neg = (bus.op == OP_DIV) & bus.rt_val[WIDTH-1];

  assign bus.start = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      rem_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      sgn_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      zero_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      rem_reg   <= rem_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      sgn_reg   <= sgn_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      zero_reg  <= zero_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    rem_next   = rem_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    sgn_next   = sgn_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    zero_next  = zero_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // A flush arriving together with a new op discards the op.
        if (!bus.cancel) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              a_next     = bus.rs_val;
              b_next     = bus.rt_val;
              sgn_next   = (bus.op == OP_MULT);
              cnt_next   = CW'(MULT_CYCLES - 1);
              state_next = MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_next     = rs_neg ? -bus.rs_val : bus.rs_val;
              b_next     = rt_neg ? -bus.rt_val : bus.rt_val;
              rem_next   = '0;
              neg_q_next = rs_neg ^ rt_neg;
              neg_r_next = rs_neg;
              zero_next  = (bus.rt_val == '0);
              cnt_next   = CW'(WIDTH - 1);
              state_next = DIV;
            end
            OP_MTHI: hi_next = bus.rs_val;
            OP_MTLO: lo_next = bus.rs_val;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          hi_next    = product[2*WIDTH-1:WIDTH];
          lo_next    = product[WIDTH-1:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DIV: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else begin
          if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            a_next   = {a_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_next = {rem_reg[WIDTH-2:0], a_reg[WIDTH-1]};
            a_next   = {a_reg[WIDTH-2:0], 1'b0};
          end
          if (cnt_reg == '0) state_next = FIX;
          else               cnt_next   = cnt_reg - CW'(1);
        end
      end
      FIX: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else begin
          // Divide-by-zero still completes and pulses done but leaves HI/LO alone.
          if (!zero_reg) begin
            lo_next = neg_q_reg ? -a_reg : a_reg;
            hi_next = neg_r_reg ? -rem_reg : rem_reg;
          end
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: an arithmetic reference model is checked every cycle,
// plus hand-computed literal results for each directed operation.
module tb_mdu_iter;
  localparam int W  = 32;
  localparam int MC = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W), .MULT_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  bit          m_busy = 0, m_done = 0, m_wr = 0;
  int          m_cnt = 0;

  function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint x, y;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    return 64'(x * y);
  endfunction

  // Returns {remainder, quotient}; caller guarantees b != 0.
  function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint x, y, q, r;
    logic [63:0] qq, rr;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    q  = x / y;
    r  = x % y;
    qq = q;
    rr = r;
    return {rr[31:0], qq[31:0]};
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [63:0] res;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_cnt = 0; m_wr = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (bus.cancel) begin
          m_busy = 0;
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 0;
            m_done = 1;
            if (m_wr) begin
              m_hi = r_hi;
              m_lo = r_lo;
            end
          end
        end
      end else if (!bus.cancel) begin
        case (bus.op)
          3'd1, 3'd2: begin
            res  = f_mul(bus.rs_val, bus.rt_val, bus.op == 3'd1);
            r_hi = res[63:32];
            r_lo = res[31:0];
            m_cnt = MC; m_busy = 1; m_wr = 1;
          end
          3'd3, 3'd4: begin
            m_wr = (bus.rt_val != 0);
            if (m_wr) begin
              res  = f_div(bus.rs_val, bus.rt_val, bus.op == 3'd3);
              r_hi = res[63:32];
              r_lo = res[31:0];
            end
            m_cnt = W + 1; m_busy = 1;
          end
          3'd5: m_hi = bus.rs_val;
          3'd6: m_lo = bus.rs_val;
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    bit exp_start;
    exp_start = (bus.op >= 3'd1) && (bus.op <= 3'd4);
    tests++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== m_busy ||
        bus.done !== m_done || bus.start !== exp_start) begin
      fails++;
      $display("FAIL cycle_model t=%0t: got hi=%h lo=%h busy=%b done=%b start=%b, required hi=%h lo=%h busy=%b done=%b start=%b",
               $time, bus.hi, bus.lo, bus.busy, bus.done, bus.start,
               m_hi, m_lo, m_busy, m_done, exp_start);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Present op for exactly one rising edge (call at posedge+2).
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.rs_val = a; bus.rt_val = b;
    @(posedge clk); #2;
    bus.op = 3'd0;
  endtask

  task automatic wait_done(input string name, output int busy_cyc, output int done_cnt);
    bit seen;
    seen = 0; busy_cyc = 0; done_cnt = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin done_cnt++; seen = 1; end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done, required done within 100 cycles", name);
    end
    @(negedge clk);
    if (bus.done) done_cnt++;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output int done_cnt);
    @(posedge clk); #2;
    start_op(op, a, b);
    wait_done(name, busy_cyc, done_cnt);
  endtask

  initial begin
    int bc, dc;
    bus.op = 3'd0; bus.rs_val = '0; bus.rt_val = '0; bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", bus.hi, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    #1;
    reset = 1'b0;
    // First op accepted at the first edge after release
    start_op(3'd1, 32'hFFFFFFFD, 32'd7);
    wait_done("mult", bc, dc);
    check("mult_busy_cycles", 32'(bc), 32'd5);
    check("mult_done_pulses", 32'(dc), 32'd1);
    check("mult_hi", bus.hi, 32'hFFFFFFFF);
    check("mult_lo", bus.lo, 32'hFFFFFFEB);
    check("model_mult_lo", m_lo, 32'hFFFFFFEB);

    run_op("divu", 3'd4, 32'd100, 32'd7, bc, dc);
    check("divu_busy_cycles", 32'(bc), 32'd33);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);
    check("model_divu_hi", m_hi, 32'd2);

    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, bc, dc);
    check("multu_hi", bus.hi, 32'd1);
    check("multu_lo", bus.lo, 32'hFFFFFFFE);

    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, bc, dc);
    check("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    check("div_neg_hi", bus.hi, 32'hFFFFFFFF);
    check("model_div_neg_lo", m_lo, 32'hFFFFFFFD);

    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, bc, dc);
    check("div_ovf_lo", bus.lo, 32'h80000000);
    check("div_ovf_hi", bus.hi, 32'h0);

    run_op("div_negb", 3'd3, 32'd7, 32'hFFFFFFFE, bc, dc);
    check("div_negb_lo", bus.lo, 32'hFFFFFFFD);
    check("div_negb_hi", bus.hi, 32'd1);

    run_op("divu_big", 3'd4, 32'hFFFFFFFF, 32'h10, bc, dc);
    check("divu_big_lo", bus.lo, 32'h0FFFFFFF);
    check("divu_big_hi", bus.hi, 32'hF);

    run_op("mult_minneg", 3'd1, 32'h80000000, 32'h80000000, bc, dc);
    check("mult_minneg_hi", bus.hi, 32'h40000000);
    check("mult_minneg_lo", bus.lo, 32'h0);

    // Divide by zero keeps HI/LO
    @(posedge clk); #2; start_op(3'd5, 32'h11, 32'h0);
    start_op(3'd6, 32'h22, 32'h0);
    @(negedge clk);
    check("mthi_hi", bus.hi, 32'h11);
    check("mtlo_lo", bus.lo, 32'h22);
    run_op("divz", 3'd4, 32'd55, 32'd0, bc, dc);
    check("divz_busy_cycles", 32'(bc), 32'd33);
    check("divz_done_pulses", 32'(dc), 32'd1);
    check("divz_hi", bus.hi, 32'h11);
    check("divz_lo", bus.lo, 32'h22);

    // Cancel at cycle 10 of a divide; mtlo while busy is ignored
    @(posedge clk); #2;
    start_op(3'd3, 32'd1000, 32'd3);
    bus.op = 3'd6; bus.rs_val = 32'h5A;
    repeat (4) @(posedge clk);
    #2; bus.op = 3'd0;
    repeat (5) @(posedge clk);
    #2; bus.cancel = 1'b1;
    @(posedge clk); #2; bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 32'(bus.busy), 32'h0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    check("cancel_no_done", 32'(dc), 32'd0);
    check("cancel_hi", bus.hi, 32'h11);
    check("cancel_lo", bus.lo, 32'h22);

    // Cancel beats an op while idle
    @(posedge clk); #2;
    bus.cancel = 1'b1;
    start_op(3'd1, 32'd3, 32'd4);
    bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_idle_busy", 32'(bus.busy), 32'h0);

    // Asynchronous reset mid-multiply
    @(posedge clk); #2;
    start_op(3'd1, 32'd3, 32'd4);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("areset_hi", bus.hi, 32'h0);
    check("areset_lo", bus.lo, 32'h0);
    check("areset_busy", 32'(bus.busy), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    check("areset_no_commit", 32'(dc), 32'd0);
    @(posedge clk); #2;
    start_op(3'd5, 32'h1234, 32'h0);
    @(negedge clk);
    check("post_reset_mthi", bus.hi, 32'h1234);
    check("post_reset_lo", bus.lo, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have parameter MULT_CYCLES, default 5, giving the multiply latency in cycles; legal range is 1..63.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port op, input, 3 bits: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
REQ-006 The block SHALL have port rs_val, input, WIDTH bits: operand A (dividend, multiplicand, or mthi/mtlo data).
REQ-007 The block SHALL have port rt_val, input, WIDTH bits: operand B (divisor or multiplier).
REQ-008 The block SHALL have port cancel, input, 1 bit: abort the in-flight operation (exception flush).
REQ-009 The block SHALL have port hi, output, WIDTH bits: the architectural HI register.
REQ-010 The block SHALL have port lo, output, WIDTH bits: the architectural LO register.
REQ-011 The block SHALL have port start, output, 1 bit: combinational, high when op is mult, multu, div or divu.
REQ-012 The block SHALL have port busy, output, 1 bit: registered, high while an operation is in flight.
REQ-013 The block SHALL have port done, output, 1 bit: registered, a one-cycle pulse on the edge where HI/LO commit.

Function
REQ-014 The block SHALL use FSM states IDLE, MUL, DIV and FIX; the state SHALL return to IDLE after every commit or cancel.
REQ-015 In IDLE, an arithmetic op SHALL be accepted at edge k: operands are latched and busy goes high at that same edge.
REQ-016 Multiply SHALL compute the full 2*WIDTH-bit product, signed for mult and unsigned for multu.
REQ-017 The upper half of the product SHALL commit to hi and the lower half to lo at edge k+MULT_CYCLES.
REQ-018 At the commit edge, busy SHALL fall and done SHALL pulse high for one cycle.
REQ-019 Divide SHALL be iterative restoring: one quotient bit per cycle in DIV, WIDTH cycles in total.
REQ-020 FIX SHALL take one cycle to apply signs; the commit SHALL occur at edge k+WIDTH+1.
REQ-021 For signed divide (div), operand magnitudes SHALL be used in DIV.
REQ-022 For div, quotient sign SHALL be sign(A) XOR sign(B), and remainder sign SHALL equal sign(A).
REQ-023 For div, the quotient SHALL be truncated toward zero.
REQ-024 Divide results SHALL commit the quotient to lo and the remainder to hi.
REQ-025 Divide-by-zero (B==0) SHALL run the full divide latency with busy high and pulse done, but SHALL leave hi and lo unchanged.
REQ-026 Signed overflow (most-negative / -1) SHALL commit lo = most-negative and hi = 0.
REQ-027 mthi SHALL write rs_val to hi, and mtlo SHALL write rs_val to lo, on the next edge, only while busy is low; the write SHALL NOT set busy.
REQ-028 Any op presented while busy is high SHALL be ignored; the upstream pipeline is responsible for stalling.
REQ-029 When cancel is high at an edge with busy high, the block SHALL abort to IDLE, drop busy, suppress done and leave hi/lo unchanged.
REQ-030 When cancel and an op are both present at an edge with busy low, cancel SHALL win and the op SHALL be discarded.
REQ-031 hi and lo SHALL change only on a commit, an mthi/mtlo write, or reset.

Reset
REQ-032 Asserting reset SHALL immediately force hi=0, lo=0, busy=0, done=0, state=IDLE and clear the iteration counters, regardless of the clock.
REQ-033 A reset during an operation SHALL discard that operation; no commit SHALL follow deassertion.
REQ-034 The first op SHALL be accepted at the first rising edge after reset deassertion.

Verification
REQ-035 mult with A=0xFFFFFFFD, B=7 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, and done pulses once.
REQ-036 divu with A=100, B=7 -> commit 33 edges after acceptance with lo=14, hi=2; multu with A=0xFFFFFFFF, B=2 -> hi=1, lo=0xFFFFFFFE.
REQ-037 div with A=0xFFFFFFF9, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div with A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 With hi=0x11, lo=0x22, divu by 0 -> busy for 33 cycles, done pulses, hi=0x11 and lo=0x22 are retained.
REQ-039 Start div, raise cancel at cycle 10 -> busy low next edge, no done pulse, hi/lo unchanged; mtlo 0x5A issued while busy -> ignored.
REQ-040 Start mult, assert reset mid-operation (between edges) -> outputs zero immediately, no commit after release; the next mthi 0x1234 -> hi=0x1234.
